// File: rtl/fetch_queue.sv
// fetch_queue: MIPS fetch front end that owns the PC, drives a 1-cycle instruction memory and buffers results.
// Optional macro FQ_BYPASS_EN forwards a live response straight to decode when the FIFO is empty.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic [AW-1:0]          imem_addr,
    output logic                   imem_en,
    input  logic [31:0]            imem_rdata,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [31:0]            id_instr,
    output logic [31:0]            id_pc4,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        hold;
    entry_t        head_entry;
    entry_t        out_entry;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   pc;
    logic [31:0]   inflight_pc4;
    logic          inflight;
    logic          kill;
    logic          live;
    logic          bypass;
    logic          pop;
    logic          fifo_pop;
    logic          push;
    logic          issue;
    logic [OW-1:0] occupancy;

    // A response is live unless a redirect discards it now or killed it earlier.
    assign live = inflight & ~kill & ~redirect;

`ifdef FQ_BYPASS_EN
    assign bypass = live & (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign head_entry = mem[head];

    // NOTE: every branch assigns out_entry, so no storage is inferred here.
    always_comb begin
        if (bypass)
            out_entry = {imem_rdata, inflight_pc4};
        else if (count != '0)
            out_entry = head_entry;
        else
            out_entry = hold;
    end

    assign id_valid  = bypass | (count != '0);
    assign id_instr  = out_entry.instr;
    assign id_pc4    = out_entry.pc4;
    assign q_count   = count;
    assign imem_addr = pc[AW+1:2];

    assign pop      = id_valid & id_ready;
    assign fifo_pop = pop & ~bypass;
    assign push     = live & ~(bypass & id_ready);

    // Slots committed after this edge; a pop this cycle frees its slot for a same-cycle issue.
    assign occupancy = {1'b0, count} + OW'(inflight) - OW'(pop);
    assign issue     = ~rst & ~redirect & (occupancy < DEPTH_W);
    assign imem_en   = issue;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc4 <= '0;
            kill         <= 1'b0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            hold         <= '0;
        end else begin
            kill     <= redirect;
            inflight <= issue;
            if (issue)
                inflight_pc4 <= pc + 32'd4;

            if (redirect)
                pc <= redirect_pc & ~32'h3;
            else if (issue)
                pc <= pc + 32'd4;

            if (pop)
                hold <= out_entry;

            if (redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push)
                    tail <= tail + PW'(1);
                if (fifo_pop)
                    head <= head + PW'(1);
                count <= count + CW'(push) - CW'(fifo_pop);
            end
        end
    end

    // NOTE: entry storage is not reset; head, tail and count alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= {imem_rdata, inflight_pc4};
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register in the 5-stage MIPS core.
- Owns the PC, issues word addresses to a synchronous-read instruction memory, and buffers returned instructions with their PC+4 in a small FIFO.
- Presents one instruction per cycle to decode under a valid/ready handshake; decode stalls by deasserting ready.
- On a branch/jump redirect, flushes everything buffered or in flight and restarts fetch at the new target.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- AW, 10, instruction memory word-address width (fetch uses PC[AW+1:2]).
- RESET_PC, 32'h0000_0000, PC after reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect  in  1  branch/jump taken; pulse of one cycle or longer.
- redirect_pc  in  32  target PC; bits [1:0] ignored.
- imem_addr  out  AW  word address to instruction memory.
- imem_en  out  1  read request this cycle.
- imem_rdata  in  32  instruction, valid the cycle after imem_en.
- id_valid  out  1  id_instr and id_pc4 hold a valid instruction.
- id_ready  in  1  decode accepts this cycle; this is ~ID_HDU_Stall.
- id_instr  out  32  instruction at the FIFO head.
- id_pc4  out  32  PC+4 of that instruction.
- q_count  out  $clog2(DEPTH)+1  number of FIFO entries occupied.

Behaviour:
- Reset values: pc=RESET_PC, FIFO empty, q_count=0, id_valid=0, imem_en=0, in-flight flag=0, id_instr=0, id_pc4=0.
- Memory interface:
  - imem_addr = pc[AW+1:2] at all times.
  - Read data returns exactly 1 cycle after the request.
  - The in-flight register holds pc+4 of the outstanding request.
- Issue rule: imem_en=1 when !rst, !redirect and (q_count + inflight) < DEPTH.
  - On issue, pc <= pc+4 (32-bit wrap, no exception).
  - The FIFO can therefore never overflow; no backpressure is needed on imem_rdata.
- Response: the cycle after an issue, if not killed, push {imem_rdata, inflight_pc4} into the FIFO.
- Pop: when id_valid && id_ready, advance the head at the clock edge.
- Simultaneous push and pop: q_count is unchanged; the entry order is preserved.
- Empty: id_valid=0; id_instr and id_pc4 hold their last values (don't-care to consumers).
- Full: imem_en=0 until a pop frees a slot.
  - A pop at full allows a same-cycle issue, because the issue test uses the current q_count minus the pop.
- Redirect (highest priority):
  - Next edge: FIFO cleared (q_count<=0), pc <= {redirect_pc[31:2],2'b00}, and any in-flight response is killed.
  - The kill is done by a kill flag set on redirect and consumed by the next response.
  - imem_en=0 in the redirect cycle.
  - A pop coinciding with redirect still counts as accepted by decode; the other entries are discarded.
- Multi-cycle redirect: pc is reloaded every cycle and no fetch is issued.
- Redirect-to-output latency: the first issue happens the cycle after redirect deasserts; id_valid rises 2 cycles after that issue (1 cycle with FQ_BYPASS_EN).
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The in-flight response is dropped because the in-flight flag clears.
- Steady state with id_ready=1: 1 instruction per cycle; q_count settles at 1.

Optional Feature:
- Macro: FQ_BYPASS_EN.
- Defined:
  - When the FIFO is empty and a live response arrives, id_valid/id_instr/id_pc4 are driven combinationally from imem_rdata and inflight_pc4.
  - If id_ready=1 that cycle, the entry is consumed without a push.
  - If id_ready=0, it is pushed normally.
  - Saves 1 cycle of fetch latency.
- Undefined: outputs are always taken from the FIFO head; the FIFO is a pure registered buffer.

Test Plan:
- Reset release with id_ready=1, memory word n = 32'h1000_0000+n.
  - Required: imem_addr sequence 0,1,2,…
  - Required: id_valid rises at cycle 2 (cycle 1 with bypass), id_instr=32'h1000_0000, id_pc4=4, then one instruction per cycle.
- Hold id_ready=0 for 10 cycles after reset.
  - Required: q_count saturates at 4, imem_en=0 after the 4th issue, pc=16.
  - Then id_ready=1: instructions 0..3 pop in order with no gap and no duplicate.
- Redirect with redirect_pc=32'h0000_0103 while the queue is full and a request is in flight.
  - Required: next cycle q_count=0, no stale push.
  - Required: first delivered id_pc4=32'h0000_0104, id_instr = word 0x40.
- Redirect asserted for 3 cycles: imem_en stays 0 for all 3 cycles; pc follows the last redirect_pc value.
- rst asserted mid-stream with q_count=3: outputs clear immediately; after release, fetch restarts at RESET_PC.
- pc=32'hFFFF_FFFC, id_ready=1: next issue sees pc=0; the delivered id_pc4=0 (wrap).
